// File: rtl/hazard_pipeline_controller_pkg.sv
// Shared types and stage indices for the hazard pipeline controller and its bypass scan.
package hazard_pipeline_controller_pkg;

   typedef enum logic [1:0] {
      STAGE_NORMAL = 2'd0,
      STAGE_STALL  = 2'd1,
      STAGE_FLUSH  = 2'd2
   } stage_ctrl_t;

   typedef enum logic {
      CTRL_RUN     = 1'b0,
      CTRL_RECOVER = 1'b1
   } ctrl_state_t;

   localparam int STAGE_FETCH   = 0;
   localparam int STAGE_DECODE  = 1;
   localparam int STAGE_EXECUTE = 2;

endpackage

// File: rtl/hazard_pipeline_controller_if.sv
// Pipeline <-> hazard controller bundle. The slave side is the controller.
// HAZARD_PERF_CNT_EN adds the three 32-bit performance counters to the bundle.
interface hazard_pipeline_controller_if #(
   parameter int NUM_STAGES = 5,
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   import hazard_pipeline_controller_pkg::*;

   logic [1:0][REG_ADDR_W-1:0]            rs_addr;
   logic [1:0]                            rs_used;
   logic [1:0][DATA_W-1:0]                rf_data;
   logic [NUM_STAGES-3:0]                 prod_we;
   logic [NUM_STAGES-3:0][REG_ADDR_W-1:0] prod_rd;
   logic [NUM_STAGES-3:0]                 prod_ready;
   logic [NUM_STAGES-3:0][DATA_W-1:0]     prod_data;
   logic                                  muldiv_busy;
   logic                                  fetch_branch;
   logic                                  fetch_pred;
   logic                                  conf_valid;
   logic                                  conf_taken;
   logic                                  conf_pred;
   logic [DATA_W-1:0]                     conf_pc;

   stage_ctrl_t [NUM_STAGES-1:0]          stage_ctrl;
   logic [1:0][DATA_W-1:0]                bypass_data;
   logic [DATA_W-1:0]                     redirect_pc;
   logic                                  redirect;
   logic                                  muldiv_clear;
   logic                                  wdog_trip;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]                           perf_data_stalls;
   logic [31:0]                           perf_struct_stalls;
   logic [31:0]                           perf_flushes;
`endif

   modport master (
      output rs_addr, rs_used, rf_data, prod_we, prod_rd, prod_ready, prod_data,
      output muldiv_busy, fetch_branch, fetch_pred, conf_valid, conf_taken, conf_pred, conf_pc,
      input  stage_ctrl, bypass_data, redirect_pc, redirect, muldiv_clear, wdog_trip
`ifdef HAZARD_PERF_CNT_EN
      , input perf_data_stalls, perf_struct_stalls, perf_flushes
`endif
   );

   modport slave (
      input  rs_addr, rs_used, rf_data, prod_we, prod_rd, prod_ready, prod_data,
      input  muldiv_busy, fetch_branch, fetch_pred, conf_valid, conf_taken, conf_pred, conf_pc,
      output stage_ctrl, bypass_data, redirect_pc, redirect, muldiv_clear, wdog_trip
`ifdef HAZARD_PERF_CNT_EN
      , output perf_data_stalls, perf_struct_stalls, perf_flushes
`endif
   );

endinterface

// File: rtl/hazard_pipeline_controller_bypass_selector.sv
// Combinational producer scan for one source operand: the youngest (lowest-index) writer of
// the same non-zero register supplies the operand and its readiness.
module bypass_selector #(
   parameter int NUM_PROD   = 3,
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0]               src_addr,
   input  logic [DATA_W-1:0]                   rf_data,
   input  logic [NUM_PROD-1:0]                 prod_we,
   input  logic [NUM_PROD-1:0][REG_ADDR_W-1:0] prod_rd,
   input  logic [NUM_PROD-1:0]                 prod_ready,
   input  logic [NUM_PROD-1:0][DATA_W-1:0]     prod_data,
   output logic [DATA_W-1:0]                   src_data,
   output logic                                src_hit,
   output logic                                src_ready
);

   // Scan oldest to youngest so the lowest-index match overwrites the others.
   always_comb begin
      src_data  = rf_data;
      src_hit   = 1'b0;
      src_ready = 1'b1;
      for (int k = NUM_PROD - 1; k >= 0; k--) begin
         if (prod_we[k] && (prod_rd[k] == src_addr) && (prod_rd[k] != '0)) begin
            src_data  = prod_data[k];
            src_hit   = 1'b1;
            src_ready = prod_ready[k];
         end
      end
   end

endmodule

// File: rtl/hazard_pipeline_controller.sv
// Hazard resolution for an N-stage in-order pipeline: per-stage NORMAL/STALL/FLUSH, operand
// bypass, mispredict redirect, stall watchdog. HAZARD_PERF_CNT_EN adds per-cause perf counters.
//
// state        | meaning
// CTRL_RUN     | normal hazard resolution
// CTRL_RECOVER | after a mispredict: stage 1 flushed, data hazards from squashed ops ignored
module hazard_pipeline_controller
   import hazard_pipeline_controller_pkg::*;
#(
   parameter int NUM_STAGES    = 5,
   parameter int CONFIRM_STAGE = 2,
   parameter int DATA_W        = 32,
   parameter int REG_ADDR_W    = 5,
   parameter int WDOG_W        = 8
) (
   input logic                         clk,
   input logic                         rst,
   hazard_pipeline_controller_if.slave bus
);

   localparam int NUM_PROD     = NUM_STAGES - 2;
   localparam int STAGE_BUBBLE = STAGE_EXECUTE + 1;
   localparam int REC_W        = $clog2(CONFIRM_STAGE + 1);
   localparam logic [REC_W-1:0] REC_LOAD = REC_W'(CONFIRM_STAGE - 1);

   ctrl_state_t                  state;
   logic [REC_W-1:0]             rec_cnt;
   logic                         br_delayed;
   logic [WDOG_W-1:0]            wdog_cnt;
   logic [WDOG_W-1:0]            wdog_next;
   logic                         wdog_trip_q;

   logic [1:0]                   src_hit;
   logic [1:0]                   src_ready;
   logic                         miss;
   logic                         struct_hz;
   logic                         data_hz;
   logic                         fetch_br;
   logic                         branch_hz;
   logic                         any_stall;
   stage_ctrl_t [NUM_STAGES-1:0] ctrl_d;

   for (genvar s = 0; s < 2; s++) begin : g_src
      bypass_selector #(
         .NUM_PROD   (NUM_PROD),
         .DATA_W     (DATA_W),
         .REG_ADDR_W (REG_ADDR_W)
      ) u_bypass_selector (
         .src_addr   (bus.rs_addr[s]),
         .rf_data    (bus.rf_data[s]),
         .prod_we    (bus.prod_we),
         .prod_rd    (bus.prod_rd),
         .prod_ready (bus.prod_ready),
         .prod_data  (bus.prod_data),
         .src_data   (bus.bypass_data[s]),
         .src_hit    (src_hit[s]),
         .src_ready  (src_ready[s])
      );
   end

   assign miss      = bus.conf_valid && (bus.conf_taken != bus.conf_pred);
   assign struct_hz = bus.muldiv_busy;
   assign data_hz   = (|(bus.rs_used & src_hit & ~src_ready)) && (state == CTRL_RUN);
   assign fetch_br  = bus.fetch_branch && bus.fetch_pred;
   assign branch_hz = fetch_br || br_delayed;

   always_comb begin
      for (int i = 0; i < NUM_STAGES; i++) begin
         ctrl_d[i] = rst ? STAGE_FLUSH : STAGE_NORMAL;
      end
      if (!rst) begin
         if (miss) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
               if (i < CONFIRM_STAGE) ctrl_d[i] = STAGE_FLUSH;
            end
         end else if (struct_hz) begin
            ctrl_d[STAGE_FETCH]   = STAGE_STALL;
            ctrl_d[STAGE_DECODE]  = STAGE_STALL;
            ctrl_d[STAGE_EXECUTE] = STAGE_STALL;
            ctrl_d[STAGE_BUBBLE]  = STAGE_FLUSH;
         end else if (data_hz) begin
            ctrl_d[STAGE_FETCH]   = STAGE_STALL;
            ctrl_d[STAGE_DECODE]  = STAGE_STALL;
            ctrl_d[STAGE_EXECUTE] = STAGE_FLUSH;
         end else if (branch_hz) begin
            ctrl_d[STAGE_FETCH]   = STAGE_FLUSH;
         end
         if (state == CTRL_RECOVER) ctrl_d[STAGE_DECODE] = STAGE_FLUSH;
      end
   end

   always_comb begin
      any_stall = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (ctrl_d[i] == STAGE_STALL) any_stall = 1'b1;
      end
   end

   // Saturating: a stuck stall must never wrap back to a quiet count.
   always_comb begin
      wdog_next = '0;
      if (any_stall) wdog_next = (wdog_cnt == '1) ? wdog_cnt : wdog_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= CTRL_RUN;
         rec_cnt     <= '0;
         br_delayed  <= 1'b0;
         wdog_cnt    <= '0;
         wdog_trip_q <= 1'b0;
      end else begin
         if (miss) begin
            state   <= CTRL_RECOVER;
            rec_cnt <= REC_LOAD;
         end else if (state == CTRL_RECOVER) begin
            if (rec_cnt <= REC_W'(1)) begin
               state   <= CTRL_RUN;
               rec_cnt <= '0;
            end else begin
               rec_cnt <= rec_cnt - 1'b1;
            end
         end

         if (miss) begin
            br_delayed <= 1'b0;
         end else if (!(struct_hz || data_hz)) begin
            br_delayed <= fetch_br;
         end

         wdog_cnt <= wdog_next;
         if (wdog_next == '1) wdog_trip_q <= 1'b1;
      end
   end

   assign bus.stage_ctrl   = ctrl_d;
   assign bus.redirect     = miss && !rst;
   assign bus.redirect_pc  = bus.conf_pc;
   assign bus.muldiv_clear = miss && struct_hz && !rst;
   assign bus.wdog_trip    = wdog_trip_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_data_q;
   logic [31:0] perf_struct_q;
   logic [31:0] perf_flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_data_q   <= '0;
         perf_struct_q <= '0;
         perf_flush_q  <= '0;
      end else begin
         if (!miss && !struct_hz && data_hz) perf_data_q <= perf_data_q + 32'd1;
         if (!miss && struct_hz) perf_struct_q <= perf_struct_q + 32'd1;
         if (miss) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign bus.perf_data_stalls   = perf_data_q;
   assign bus.perf_struct_stalls = perf_struct_q;
   assign bus.perf_flushes       = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_pipeline_controller.sv
// Self-checking bench for hazard_pipeline_controller: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_pipeline_controller;
   import hazard_pipeline_controller_pkg::*;

   localparam int NS   = 5;
   localparam int CS   = 2;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int WW   = 8;
   localparam int NP   = NS - 2;
   localparam int WMAX = (1 << WW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   // model state
   int m_rec_left = 0;
   int m_stall_run = 0;
   bit m_brd = 1'b0;
   bit m_trip = 1'b0;

   // model outputs for the current cycle
   logic [2*NS-1:0] e_ctrl;
   logic [DW-1:0]   e_byp [2];
   bit e_redirect, e_clear, e_stall, e_data, e_miss;

   hazard_pipeline_controller_if #(.NUM_STAGES(NS), .DATA_W(DW), .REG_ADDR_W(AW)) bus ();

   hazard_pipeline_controller #(
      .NUM_STAGES(NS), .CONFIRM_STAGE(CS), .DATA_W(DW), .REG_ADDR_W(AW), .WDOG_W(WW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*NS-1:0] pk(input int s0, input int s1, input int s2, input int s3, input int s4);
      logic [2*NS-1:0] v;
      v = {2'(s4), 2'(s3), 2'(s2), 2'(s1), 2'(s0)};
      return v;
   endfunction

   task automatic quiet();
      bus.rs_addr      = '0;
      bus.rs_used      = '0;
      bus.rf_data      = '0;
      bus.prod_we      = '0;
      bus.prod_rd      = '0;
      bus.prod_ready   = '1;
      bus.prod_data    = '0;
      bus.muldiv_busy  = 1'b0;
      bus.fetch_branch = 1'b0;
      bus.fetch_pred   = 1'b0;
      bus.conf_valid   = 1'b0;
      bus.conf_taken   = 1'b0;
      bus.conf_pred    = 1'b0;
      bus.conf_pc      = '0;
   endtask

   task automatic model_eval();
      int st [NS];
      bit haz = 1'b0;
      bit recovering = (m_rec_left > 0);
      for (int s = 0; s < 2; s++) begin
         int win = -1;
         for (int k = 0; k < NP; k++) begin
            if (win < 0 && bus.prod_we[k] && bus.prod_rd[k] == bus.rs_addr[s] && bus.rs_addr[s] != 0) win = k;
         end
         e_byp[s] = (win >= 0) ? bus.prod_data[win] : bus.rf_data[s];
         if (win >= 0 && bus.rs_used[s] && !bus.prod_ready[win]) haz = 1'b1;
      end
      e_miss = bus.conf_valid && (bus.conf_taken != bus.conf_pred);
      e_data = haz && !recovering;
      for (int i = 0; i < NS; i++) st[i] = rst ? 2 : 0;
      if (!rst) begin
         if (e_miss) begin
            for (int i = 0; i < CS; i++) st[i] = 2;
         end else if (bus.muldiv_busy) begin
            st[0] = 1; st[1] = 1; st[2] = 1; st[3] = 2;
         end else if (e_data) begin
            st[0] = 1; st[1] = 1; st[2] = 2;
         end else if ((bus.fetch_branch && bus.fetch_pred) || m_brd) begin
            st[0] = 2;
         end
         if (recovering) st[1] = 2;
      end
      e_stall = 1'b0;
      for (int i = 0; i < NS; i++) begin
         if (st[i] == 1) e_stall = 1'b1;
         e_ctrl[2*i +: 2] = 2'(st[i]);
      end
      e_redirect = !rst && e_miss;
      e_clear    = e_redirect && bus.muldiv_busy;
   endtask

   task automatic model_update();
      if (rst) begin
         m_rec_left = 0; m_brd = 1'b0; m_stall_run = 0; m_trip = 1'b0;
      end else begin
         if (e_miss) m_rec_left = CS - 1;
         else if (m_rec_left > 0) m_rec_left--;
         if (e_miss) m_brd = 1'b0;
         else if (!(bus.muldiv_busy || e_data)) m_brd = bus.fetch_branch && bus.fetch_pred;
         m_stall_run = e_stall ? ((m_stall_run < WMAX) ? m_stall_run + 1 : WMAX) : 0;
         if (m_stall_run == WMAX) m_trip = 1'b1;
      end
   endtask

   task automatic settle();
      #1;
      model_eval();
      chk("ctrl", 64'(bus.stage_ctrl), 64'(e_ctrl));
      chk("bypass0", 64'(bus.bypass_data[0]), 64'(e_byp[0]));
      chk("bypass1", 64'(bus.bypass_data[1]), 64'(e_byp[1]));
      chk("redirect", 64'(bus.redirect), 64'(e_redirect));
      if (e_redirect) chk("redirect_pc", 64'(bus.redirect_pc), 64'(bus.conf_pc));
      chk("muldiv_clear", 64'(bus.muldiv_clear), 64'(e_clear));
      chk("wdog_trip", 64'(bus.wdog_trip), 64'(m_trip));
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      quiet();
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // reset
      settle();
      chk("rst_ctrl", 64'(bus.stage_ctrl), 64'(pk(2, 2, 2, 2, 2)));
      advance();
      rst = 1'b0;
      settle();
      chk("post_rst_ctrl", 64'(bus.stage_ctrl), 64'(pk(0, 0, 0, 0, 0)));
      chk("post_rst_trip", 64'(bus.wdog_trip), 64'd0);
      advance();

      // 1: ready producer forwarded, youngest match wins
      bus.rs_addr[0] = 5'd5; bus.rs_used = 2'b01; bus.rf_data[0] = 32'h1111;
      bus.prod_we = 3'b001; bus.prod_rd[0] = 5'd5; bus.prod_data[0] = 32'hAA;
      settle();
      chk("t1_byp", 64'(bus.bypass_data[0]), 64'hAA);
      chk("t1_ctrl", 64'(bus.stage_ctrl), 64'(pk(0, 0, 0, 0, 0)));
      advance();
      bus.prod_we = 3'b110; bus.prod_rd[1] = 5'd5; bus.prod_rd[2] = 5'd5;
      bus.prod_data[1] = 32'hBB; bus.prod_data[2] = 32'hCC;
      settle();
      chk("t1_lowest", 64'(bus.bypass_data[0]), 64'hBB);
      advance();

      // 2: load-use stall then release
      bus.prod_we = 3'b001; bus.prod_ready = 3'b110;
      settle();
      chk("t2_stall", 64'(bus.stage_ctrl), 64'(pk(1, 1, 2, 0, 0)));
      advance();
      bus.prod_ready = 3'b111;
      settle();
      chk("t2_release", 64'(bus.stage_ctrl), 64'(pk(0, 0, 0, 0, 0)));
      advance();

      // 3: mispredict during data stall
      bus.prod_ready = 3'b110;
      bus.conf_valid = 1'b1; bus.conf_taken = 1'b1; bus.conf_pred = 1'b0; bus.conf_pc = 32'h100;
      settle();
      chk("t3_redirect", 64'(bus.redirect), 64'd1);
      chk("t3_pc", 64'(bus.redirect_pc), 64'h100);
      chk("t3_ctrl", 64'(bus.stage_ctrl), 64'(pk(2, 2, 0, 0, 0)));
      advance();
      bus.conf_valid = 1'b0;
      settle();
      chk("t3_recover", 64'(bus.stage_ctrl), 64'(pk(0, 2, 0, 0, 0)));
      advance();
      settle();
      advance();

      // 4: structural stall with mispredict on its second cycle
      quiet();
      bus.muldiv_busy = 1'b1;
      settle();
      chk("t4_struct", 64'(bus.stage_ctrl), 64'(pk(1, 1, 1, 2, 0)));
      chk("t4_noclear", 64'(bus.muldiv_clear), 64'd0);
      advance();
      bus.conf_valid = 1'b1; bus.conf_taken = 1'b0; bus.conf_pred = 1'b1; bus.conf_pc = 32'h200;
      settle();
      chk("t4_clear", 64'(bus.muldiv_clear), 64'd1);
      chk("t4_miss_ctrl", 64'(bus.stage_ctrl), 64'(pk(2, 2, 0, 0, 0)));
      advance();
      bus.conf_valid = 1'b0;
      settle();
      chk("t4_struct_recover", 64'(bus.stage_ctrl), 64'(pk(1, 2, 1, 2, 0)));
      advance();
      bus.muldiv_busy = 1'b0;
      settle();
      chk("t4_released", 64'(bus.stage_ctrl), 64'(pk(0, 0, 0, 0, 0)));
      advance();

      // 5: watchdog trips after 255 consecutive stall cycles, sticky until reset
      rst = 1'b1; settle(); advance(); rst = 1'b0;
      bus.muldiv_busy = 1'b1;
      repeat (254) begin settle(); advance(); end
      settle();
      chk("t5_not_yet", 64'(bus.wdog_trip), 64'd0);
      advance();
      settle();
      chk("t5_trip", 64'(bus.wdog_trip), 64'd1);
      advance();
      bus.muldiv_busy = 1'b0;
      repeat (5) begin settle(); advance(); end
      settle();
      chk("t5_sticky", 64'(bus.wdog_trip), 64'd1);
      advance();
      rst = 1'b1; settle(); advance(); rst = 1'b0;
      settle();
      chk("t5_rst_clear", 64'(bus.wdog_trip), 64'd0);
      advance();

      // 6: x0 never bypassed; reset in the middle of recovery
      quiet();
      bus.rs_addr[0] = 5'd0; bus.rs_used = 2'b01; bus.rf_data[0] = 32'h1234;
      bus.prod_we = 3'b001; bus.prod_rd[0] = 5'd0; bus.prod_ready = 3'b000; bus.prod_data[0] = 32'h55;
      settle();
      chk("t6_x0_byp", 64'(bus.bypass_data[0]), 64'h1234);
      chk("t6_x0_ctrl", 64'(bus.stage_ctrl), 64'(pk(0, 0, 0, 0, 0)));
      advance();
      quiet();
      bus.conf_valid = 1'b1; bus.conf_taken = 1'b1;
      settle(); advance();
      bus.conf_valid = 1'b0;
      rst = 1'b1;
      settle();
      chk("t6_rst_flush", 64'(bus.stage_ctrl), 64'(pk(2, 2, 2, 2, 2)));
      advance();
      rst = 1'b0;
      settle();
      chk("t6_run", 64'(bus.stage_ctrl), 64'(pk(0, 0, 0, 0, 0)));
      advance();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         for (int s = 0; s < 2; s++) begin
            bus.rs_addr[s] = AW'($urandom_range(0, 3));
            bus.rf_data[s] = DW'($urandom);
         end
         bus.rs_used = 2'($urandom);
         for (int k = 0; k < NP; k++) begin
            bus.prod_rd[k]   = AW'($urandom_range(0, 3));
            bus.prod_data[k] = DW'($urandom);
         end
         bus.prod_we      = NP'($urandom);
         bus.prod_ready   = NP'($urandom);
         bus.muldiv_busy  = ($urandom_range(0, 5) == 0);
         bus.fetch_branch = 1'($urandom);
         bus.fetch_pred   = 1'($urandom);
         bus.conf_valid   = ($urandom_range(0, 4) == 0);
         bus.conf_taken   = 1'($urandom);
         bus.conf_pred    = 1'($urandom);
         bus.conf_pc      = DW'($urandom);
         rst = ($urandom_range(0, 59) == 0);
         settle();
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
